vector_writeback_pipeline: RTL and testbench

- Producer end of the vector bypass network. Carries vector results from execute through four post-execute stages and commits them to the vector register file with a per-lane mask.
- Drives the four bypass source ports (register, write, value, mask). bypass1 is the youngest/highest-priority source, bypass4 the oldest.
- Sits between the vector execute unit and the vector register file write port.

---
 rtl/vector_writeback_pipeline.sv | 149 ++++++++++++++
 tb/tb_vector_writeback_pipeline.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_writeback_pipeline.sv
// ---------------------------------------------------------------------------
// vector_writeback_pipeline
//
// Producer end of the vector bypass network. Carries vector results from the
// execute unit through four post-execute stages and commits them to the vector
// register file with a per-lane write mask. Every stage is exposed as a bypass
// source; bypass1 is the youngest (highest priority), bypass4 the oldest.
//
// Ports:
//   clk, reset_n             clock (rising edge) and asynchronous active-low reset
//   result_*_i               execute result: valid, destination reg, value, lane mask
//   stall_i                  freeze all stages, ignore the input
//   flush_i                  kill stages 1-2, let stage 3 advance (overrides stall_i)
//   bypassN_*_o (N=1..4)     stage N register / write / value / mask
//   rf_*_o                   register file write port, mirrors stage 4
//   occupancy_o              number of valid stages (0..4)
// ---------------------------------------------------------------------------
module vector_writeback_pipeline #(
    parameter int unsigned NUM_LANES = 16,
    parameter int unsigned STAGES    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic                   result_valid_i,
    input  logic [6:0]             result_register_i,
    input  logic [NUM_LANES*32-1:0] result_value_i,
    input  logic [NUM_LANES-1:0]   result_mask_i,
    input  logic                   stall_i,
    input  logic                   flush_i,

    output logic [6:0]             bypass1_register_o,
    output logic                   bypass1_write_o,
    output logic [NUM_LANES*32-1:0] bypass1_value_o,
    output logic [NUM_LANES-1:0]   bypass1_mask_o,
    output logic [6:0]             bypass2_register_o,
    output logic                   bypass2_write_o,
    output logic [NUM_LANES*32-1:0] bypass2_value_o,
    output logic [NUM_LANES-1:0]   bypass2_mask_o,
    output logic [6:0]             bypass3_register_o,
    output logic                   bypass3_write_o,
    output logic [NUM_LANES*32-1:0] bypass3_value_o,
    output logic [NUM_LANES-1:0]   bypass3_mask_o,
    output logic [6:0]             bypass4_register_o,
    output logic                   bypass4_write_o,
    output logic [NUM_LANES*32-1:0] bypass4_value_o,
    output logic [NUM_LANES-1:0]   bypass4_mask_o,

    output logic                   rf_write_o,
    output logic [6:0]             rf_register_o,
    output logic [NUM_LANES*32-1:0] rf_value_o,
    output logic [NUM_LANES-1:0]   rf_mask_o,

    output logic [2:0]             occupancy_o
);

    localparam int unsigned ValueW = NUM_LANES * 32;

    // Index 0 is stage 1 (youngest), index STAGES-1 is stage 4 (oldest).
    logic [STAGES-1:0] valid_q, valid_d;
    logic [6:0]        reg_q   [STAGES];
    logic [6:0]        reg_d   [STAGES];
    logic [ValueW-1:0] value_q [STAGES];
    logic [ValueW-1:0] value_d [STAGES];
    logic [NUM_LANES-1:0] mask_q [STAGES];
    logic [NUM_LANES-1:0] mask_d [STAGES];

    logic [STAGES-1:0] stage_write;
    logic              advance;

    // A flush still lets the oldest surviving entry drain, so stage 4 moves
    // whenever we are not purely stalled.
    assign advance = !stall_i || flush_i;

    always_comb begin
        valid_d = valid_q;
        reg_d   = reg_q;
        value_d = value_q;
        mask_d  = mask_q;

        if (advance) begin
            for (int k = 1; k < STAGES; k++) begin
                // On flush, anything coming out of stages 1 and 2 is killed.
                valid_d[k] = valid_q[k-1] && !(flush_i && (k - 1 < 2));
                reg_d[k]   = reg_q[k-1];
                value_d[k] = value_q[k-1];
                mask_d[k]  = mask_q[k-1];
            end
            if (flush_i) begin
                valid_d[0] = 1'b0;
            end else begin
                valid_d[0] = result_valid_i;
                reg_d[0]   = result_register_i;
                value_d[0] = result_value_i;
                mask_d[0]  = result_mask_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                reg_q[k]   <= '0;
                value_q[k] <= '0;
                mask_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            reg_q   <= reg_d;
            value_q <= value_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        stage_write = '0;
        occupancy_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            // A zero-mask result travels the pipe but never writes or bypasses.
            stage_write[k] = valid_q[k] && (mask_q[k] != '0);
            occupancy_o    = occupancy_o + 3'(valid_q[k]);
        end
    end

    assign bypass1_register_o = reg_q[0];
    assign bypass1_write_o    = stage_write[0];
    assign bypass1_value_o    = value_q[0];
    assign bypass1_mask_o     = mask_q[0];
    assign bypass2_register_o = reg_q[1];
    assign bypass2_write_o    = stage_write[1];
    assign bypass2_value_o    = value_q[1];
    assign bypass2_mask_o     = mask_q[1];
    assign bypass3_register_o = reg_q[2];
    assign bypass3_write_o    = stage_write[2];
    assign bypass3_value_o    = value_q[2];
    assign bypass3_mask_o     = mask_q[2];
    assign bypass4_register_o = reg_q[3];
    assign bypass4_write_o    = stage_write[3];
    assign bypass4_value_o    = value_q[3];
    assign bypass4_mask_o     = mask_q[3];

    // A stalled stage-4 entry is written only in the cycle it actually leaves.
    assign rf_write_o    = stage_write[STAGES-1] && advance;
    assign rf_register_o = reg_q[STAGES-1];
    assign rf_value_o    = value_q[STAGES-1];
    assign rf_mask_o     = mask_q[STAGES-1];

endmodule

// File: tb/tb_vector_writeback_pipeline.sv
module tb_vector_writeback_pipeline;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         result_valid_i;
    logic [6:0]   result_register_i;
    logic [511:0] result_value_i;
    logic [15:0]  result_mask_i;
    logic         stall_i;
    logic         flush_i;

    logic [6:0]   bp_reg [4];
    logic         bp_wr  [4];
    logic [511:0] bp_val [4];
    logic [15:0]  bp_msk [4];

    logic         rf_write_o;
    logic [6:0]   rf_register_o;
    logic [511:0] rf_value_o;
    logic [15:0]  rf_mask_o;
    logic [2:0]   occupancy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vector_writeback_pipeline dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .result_valid_i     (result_valid_i),
        .result_register_i  (result_register_i),
        .result_value_i     (result_value_i),
        .result_mask_i      (result_mask_i),
        .stall_i            (stall_i),
        .flush_i            (flush_i),
        .bypass1_register_o (bp_reg[0]),
        .bypass1_write_o    (bp_wr[0]),
        .bypass1_value_o    (bp_val[0]),
        .bypass1_mask_o     (bp_msk[0]),
        .bypass2_register_o (bp_reg[1]),
        .bypass2_write_o    (bp_wr[1]),
        .bypass2_value_o    (bp_val[1]),
        .bypass2_mask_o     (bp_msk[1]),
        .bypass3_register_o (bp_reg[2]),
        .bypass3_write_o    (bp_wr[2]),
        .bypass3_value_o    (bp_val[2]),
        .bypass3_mask_o     (bp_msk[2]),
        .bypass4_register_o (bp_reg[3]),
        .bypass4_write_o    (bp_wr[3]),
        .bypass4_value_o    (bp_val[3]),
        .bypass4_mask_o     (bp_msk[3]),
        .rf_write_o         (rf_write_o),
        .rf_register_o      (rf_register_o),
        .rf_value_o         (rf_value_o),
        .rf_mask_o          (rf_mask_o),
        .occupancy_o        (occupancy_o)
    );

    // Reference: the in-flight results, ordered youngest (slot 0) to oldest (slot 3).
    typedef struct {
        logic         v;
        logic [6:0]   r;
        logic [511:0] d;
        logic [15:0]  m;
    } ent_t;

    ent_t mdl [4];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            mdl[k].v = 1'b0;
            mdl[k].r = '0;
            mdl[k].d = '0;
            mdl[k].m = '0;
        end
    endtask

    task automatic check_model();
        int cnt;
        logic retire;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp%0d_write", k + 1), 512'(bp_wr[k]),
                512'(mdl[k].v && (mdl[k].m != 16'h0)));
            if (mdl[k].v) begin
                chk($sformatf("bp%0d_reg", k + 1), 512'(bp_reg[k]), 512'(mdl[k].r));
                chk($sformatf("bp%0d_val", k + 1), bp_val[k], mdl[k].d);
                chk($sformatf("bp%0d_mask", k + 1), 512'(bp_msk[k]), 512'(mdl[k].m));
                cnt++;
            end
        end
        // The oldest result retires to the RF only when it actually leaves.
        retire = mdl[3].v && (mdl[3].m != 16'h0) && (!stall_i || flush_i);
        chk("rf_write", 512'(rf_write_o), 512'(retire));
        if (mdl[3].v) begin
            chk("rf_reg", 512'(rf_register_o), 512'(mdl[3].r));
            chk("rf_val", rf_value_o, mdl[3].d);
            chk("rf_mask", 512'(rf_mask_o), 512'(mdl[3].m));
        end
        chk("occupancy", 512'(occupancy_o), 512'(cnt));
    endtask

    task automatic drive(input logic v, input logic [6:0] r, input logic [511:0] d,
                         input logic [15:0] m, input logic st, input logic fl);
        result_valid_i    = v;
        result_register_i = r;
        result_value_i    = d;
        result_mask_i     = m;
        stall_i           = st;
        flush_i           = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 7'h0, 512'h0, 16'h0, 1'b0, 1'b0);
    endtask

    // Check against the reference, then take one clock edge.
    task automatic tick();
        ent_t nx [4];
        check_model();
        nx = mdl;
        if (flush_i) begin
            nx[3] = mdl[2];
            nx[2].v = 1'b0;
            nx[1].v = 1'b0;
            nx[0].v = 1'b0;
        end else if (!stall_i) begin
            nx[3] = mdl[2];
            nx[2] = mdl[1];
            nx[1] = mdl[0];
            nx[0].v = result_valid_i;
            nx[0].r = result_register_i;
            nx[0].d = result_value_i;
            nx[0].m = result_mask_i;
        end
        @(posedge clk);
        mdl = nx;
        @(negedge clk);
    endtask

    function automatic logic [511:0] rand_value();
        logic [511:0] rv;
        for (int i = 0; i < 16; i++) rv[i*32 +: 32] = $urandom;
        return rv;
    endfunction

    initial begin
        logic [511:0] lane_idx;
        logic [511:0] rv;
        logic [2:0]   occ_seq [5];
        int           rf_cnt;

        occ_seq[0] = 3'd1; occ_seq[1] = 3'd1; occ_seq[2] = 3'd1;
        occ_seq[3] = 3'd1; occ_seq[4] = 3'd0;
        for (int i = 0; i < 16; i++) lane_idx[i*32 +: 32] = 32'(i);

        reset_n = 1'b0;
        model_clear();
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("reset_occ", 512'(occupancy_o), 512'h0);
        chk("reset_rf_write", 512'(rf_write_o), 512'h0);
        chk("reset_bp4_val", bp_val[3], 512'h0);
        chk("reset_bp1_reg", 512'(bp_reg[0]), 512'h0);
        reset_n = 1'b1;
        idle();

        // Single full-mask result walking all four stages.
        drive(1'b1, 7'h05, lane_idx, 16'hFFFF, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            idle();
            chk("t1_occ", 512'(occupancy_o), 512'(occ_seq[i-1]));
            chk("t1_rf_write", 512'(rf_write_o), 512'(i == 4));
            if (i <= 4) chk("t1_bp_write", 512'(bp_wr[i-1]), 512'h1);
            tick();
        end

        // Back-to-back results to the same register with disjoint masks.
        drive(1'b1, 7'h03, rand_value(), 16'h00FF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 7'h03, rand_value(), 16'hFF00, 1'b0, 1'b0);
        tick();
        idle();
        chk("b2b_bp1_mask", 512'(bp_msk[0]), 512'h0000_FF00);
        chk("b2b_bp2_mask", 512'(bp_msk[1]), 512'h0000_00FF);
        tick();
        tick();
        chk("b2b_rf1", 512'(rf_write_o), 512'h1);
        chk("b2b_rf1_mask", 512'(rf_mask_o), 512'h00FF);
        tick();
        chk("b2b_rf2", 512'(rf_write_o), 512'h1);
        chk("b2b_rf2_mask", 512'(rf_mask_o), 512'hFF00);
        tick();
        chk("b2b_rf_done", 512'(rf_write_o), 512'h0);
        tick();

        // Stall while a result sits in stage 4: exactly one RF write.
        drive(1'b1, 7'h11, rand_value(), 16'h0F0F, 1'b0, 1'b0);
        tick();
        idle(); tick(); tick(); tick();
        rf_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'h22, rand_value(), 16'hFFFF, 1'b1, 1'b0);
            chk("stall_rf_write", 512'(rf_write_o), 512'h0);
            chk("stall_bp4_reg", 512'(bp_reg[3]), 512'h11);
            if (rf_write_o) rf_cnt++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            if (rf_write_o) rf_cnt++;
            tick();
        end
        chk("stall_rf_count", 512'(rf_cnt), 512'd1);

        // Flush with all four stages full (reg 4 youngest).
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 7'(i), rand_value(), 16'hFFFF, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 7'h7F, rand_value(), 16'hFFFF, 1'b1, 1'b1);
        chk("flush_rf_write", 512'(rf_write_o), 512'h1);
        chk("flush_rf_reg", 512'(rf_register_o), 512'h1);
        tick();
        idle();
        chk("flush_occ", 512'(occupancy_o), 512'h1);
        chk("flush_bp4_reg", 512'(bp_reg[3]), 512'h2);
        chk("flush_bp1_write", 512'(bp_wr[0]), 512'h0);
        chk("flush_bp2_write", 512'(bp_wr[1]), 512'h0);
        tick(); tick();

        // Zero-mask result: counted in occupancy, never writes.
        drive(1'b1, 7'h09, rand_value(), 16'h0000, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("zmask_occ", 512'(occupancy_o), 512'(i < 4));
            chk("zmask_rf", 512'(rf_write_o), 512'h0);
            tick();
        end

        // Asynchronous reset with three results in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'(8 + i), rand_value(), 16'hFFFF, 1'b0, 1'b0);
            tick();
        end
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        chk("arst_occ", 512'(occupancy_o), 512'h0);
        chk("arst_rf_write", 512'(rf_write_o), 512'h0);
        chk("arst_bp1_write", 512'(bp_wr[0]), 512'h0);
        chk("arst_bp3_val", bp_val[2], 512'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("arst_no_rf", 512'(rf_write_o), 512'h0);
            tick();
        end

        // Randomized traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            rv = rand_value();
            case ($urandom_range(0, 3))
                0:       drive($urandom_range(0, 1) == 1, 7'($urandom), rv, 16'h0000,
                               $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
                1:       drive($urandom_range(0, 1) == 1, 7'($urandom), rv, 16'hFFFF,
                               $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
                default: drive($urandom_range(0, 1) == 1, 7'($urandom), rv, 16'($urandom),
                               $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            endcase
            tick();
        end
        idle();
        check_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
